instruction_decoder: RTL and testbench

Registered control-word decoder for the pipelined 32-bit RISC datapath. It splits the 32-bit instruction register into register-address fields and a 7-bit opcode, and produces the full control vector for the register file, function unit, constant unit, memory, and PC/branch logic. It sits between the instruction-fetch stage register and the decode/operand-fetch stage. All outputs are registered with one clock of latency.

---
 rtl/instruction_decoder.sv | 163 ++++++++++++++++
 tb/tb_instruction_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instruction_decoder.sv
// instruction_decoder
// Registered control-word decoder for the 32-bit RISC pipeline. Splits the
// instruction register into register-address fields and a 7-bit opcode, then
// registers the full control vector with one clock of latency.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous active-high reset; loads the NOP vector with zero addresses
//   IR     instruction: opcode [31:25], DR [24:20], SA [19:15], SB [14:10]
//   RW     register-file write enable
//   DA     destination register address
//   MD     writeback select: 00 function unit, 01 memory, 10 set-less-than
//   BS     PC select: 00 PC+1, 01 cond branch, 10 jump reg, 11 PC-relative jump
//   PS     branch polarity: 0 on zero, 1 on nonzero
//   MW     data-memory write enable
//   FS     function-unit select
//   MB     bus B select: 0 register, 1 constant unit
//   MA     bus A select: 0 register, 1 PC+1
//   AA     A-port register address
//   BA     B-port register address
//   CS     constant unit: 0 zero-fill, 1 sign-extend
module instruction_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    output logic        RW,
    output logic [4:0]  DA,
    output logic [1:0]  MD,
    output logic [1:0]  BS,
    output logic        PS,
    output logic        MW,
    output logic [4:0]  FS,
    output logic        MB,
    output logic        MA,
    output logic [4:0]  AA,
    output logic [4:0]  BA,
    output logic        CS
);

    localparam logic [6:0] OP_NOP = 7'b0000000;
    localparam logic [6:0] OP_MOV = 7'b1000000;
    localparam logic [6:0] OP_ADD = 7'b0000010;
    localparam logic [6:0] OP_SUB = 7'b0000101;
    localparam logic [6:0] OP_AND = 7'b0001000;
    localparam logic [6:0] OP_OR  = 7'b0001010;
    localparam logic [6:0] OP_XOR = 7'b0001100;
    localparam logic [6:0] OP_NOT = 7'b0101110;
    localparam logic [6:0] OP_SLT = 7'b1100101;
    localparam logic [6:0] OP_ADI = 7'b0100010;
    localparam logic [6:0] OP_SBI = 7'b0100101;
    localparam logic [6:0] OP_AIU = 7'b1100010;
    localparam logic [6:0] OP_SIU = 7'b1000101;
    localparam logic [6:0] OP_ANI = 7'b0101000;
    localparam logic [6:0] OP_ORI = 7'b0101010;
    localparam logic [6:0] OP_XRI = 7'b0101100;
    localparam logic [6:0] OP_LSL = 7'b0110010;
    localparam logic [6:0] OP_LSR = 7'b0110001;
    localparam logic [6:0] OP_LD  = 7'b0100001;
    localparam logic [6:0] OP_ST  = 7'b0000001;
    localparam logic [6:0] OP_BZ  = 7'b0100000;
    localparam logic [6:0] OP_BNZ = 7'b1100000;
    localparam logic [6:0] OP_JMR = 7'b1100001;
    localparam logic [6:0] OP_JMP = 7'b1000100;
    localparam logic [6:0] OP_JML = 7'b0000111;

    localparam logic [4:0] FS_PASS = 5'b00000;
    localparam logic [4:0] FS_ADD  = 5'b00010;
    localparam logic [4:0] FS_SUB  = 5'b00101;
    localparam logic [4:0] FS_AND  = 5'b01000;
    localparam logic [4:0] FS_OR   = 5'b01010;
    localparam logic [4:0] FS_XOR  = 5'b01100;
    localparam logic [4:0] FS_NOT  = 5'b01110;
    localparam logic [4:0] FS_SHL  = 5'b10100;
    localparam logic [4:0] FS_SHR  = 5'b11000;

    logic [6:0] opcode;
    logic       d_rw, d_ps, d_mw, d_mb, d_ma, d_cs;
    logic [1:0] d_md, d_bs;
    logic [4:0] d_fs;

    // The low immediate bits feed the constant unit directly; they carry
    // nothing the control decode needs.
    logic unused_imm;
    assign unused_imm = ^IR[9:0];

    assign opcode = IR[31:25];

    always_comb begin
        d_rw = 1'b0;
        d_md = 2'b00;
        d_bs = 2'b00;
        d_ps = 1'b0;
        d_mw = 1'b0;
        d_fs = FS_PASS;
        d_mb = 1'b0;
        d_ma = 1'b0;
        d_cs = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_MOV: d_rw = 1'b1;
            OP_ADD: begin d_rw = 1'b1; d_fs = FS_ADD; end
            OP_SUB: begin d_rw = 1'b1; d_fs = FS_SUB; end
            OP_AND: begin d_rw = 1'b1; d_fs = FS_AND; end
            OP_OR:  begin d_rw = 1'b1; d_fs = FS_OR;  end
            OP_XOR: begin d_rw = 1'b1; d_fs = FS_XOR; end
            OP_NOT: begin d_rw = 1'b1; d_fs = FS_NOT; end
            // Subtract sets N/V; writeback takes N xor V.
            OP_SLT: begin d_rw = 1'b1; d_md = 2'b10; d_fs = FS_SUB; end
            OP_ADI: begin d_rw = 1'b1; d_fs = FS_ADD; d_mb = 1'b1; d_cs = 1'b1; end
            OP_SBI: begin d_rw = 1'b1; d_fs = FS_SUB; d_mb = 1'b1; d_cs = 1'b1; end
            OP_AIU: begin d_rw = 1'b1; d_fs = FS_ADD; d_mb = 1'b1; end
            OP_SIU: begin d_rw = 1'b1; d_fs = FS_SUB; d_mb = 1'b1; end
            OP_ANI: begin d_rw = 1'b1; d_fs = FS_AND; d_mb = 1'b1; end
            OP_ORI: begin d_rw = 1'b1; d_fs = FS_OR;  d_mb = 1'b1; end
            OP_XRI: begin d_rw = 1'b1; d_fs = FS_XOR; d_mb = 1'b1; end
            // Shift amount arrives through the zero-filled constant.
            OP_LSL: begin d_rw = 1'b1; d_fs = FS_SHL; d_mb = 1'b1; end
            OP_LSR: begin d_rw = 1'b1; d_fs = FS_SHR; d_mb = 1'b1; end
            OP_LD:  begin d_rw = 1'b1; d_md = 2'b01; end
            OP_ST:  d_mw = 1'b1;
            OP_BZ:  begin d_bs = 2'b01; d_mb = 1'b1; d_cs = 1'b1; end
            OP_BNZ: begin d_bs = 2'b01; d_ps = 1'b1; d_mb = 1'b1; d_cs = 1'b1; end
            OP_JMR: d_bs = 2'b10;
            OP_JMP: begin d_bs = 2'b11; d_mb = 1'b1; d_cs = 1'b1; end
            // Link: PC+1 on bus A passes through the function unit into DR.
            OP_JML: begin
                d_rw = 1'b1; d_bs = 2'b11; d_ma = 1'b1; d_mb = 1'b1; d_cs = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RW <= 1'b0;
            DA <= 5'd0;
            MD <= 2'b00;
            BS <= 2'b00;
            PS <= 1'b0;
            MW <= 1'b0;
            FS <= FS_PASS;
            MB <= 1'b0;
            MA <= 1'b0;
            AA <= 5'd0;
            BA <= 5'd0;
            CS <= 1'b0;
        end else begin
            RW <= d_rw;
            DA <= IR[24:20];
            MD <= d_md;
            BS <= d_bs;
            PS <= d_ps;
            MW <= d_mw;
            FS <= d_fs;
            MB <= d_mb;
            MA <= d_ma;
            AA <= IR[19:15];
            BA <= IR[14:10];
            CS <= d_cs;
        end
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: opcode table sweep plus
// hand-written reset, back-to-back and hold sequences, checked through a
// queue of expected output words.
module tb_instruction_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR;
    logic        RW, PS, MW, MB, MA, CS;
    logic [4:0]  DA, FS, AA, BA;
    logic [1:0]  MD, BS;

    instruction_decoder dut (
        .clk(clk), .reset(reset), .IR(IR),
        .RW(RW), .DA(DA), .MD(MD), .BS(BS), .PS(PS), .MW(MW),
        .FS(FS), .MB(MB), .MA(MA), .AA(AA), .BA(BA), .CS(CS)
    );

    always #5 clk = ~clk;

    // Expected word layout: {RW,MD,BS,PS,MW,FS,MB,MA,CS, DA,AA,BA}
    typedef struct {
        logic [29:0] word;
        string       name;
    } exp_t;

    typedef struct {
        logic [6:0]  op;
        logic [14:0] ctrl;
        string       name;
    } vec_t;

    exp_t  sb_q[$];
    vec_t  vecs[26];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic logic [14:0] c(input logic rw, input logic [1:0] md,
                                      input logic [1:0] bs, input logic ps,
                                      input logic mw, input logic [4:0] fs,
                                      input logic mb, input logic ma,
                                      input logic cs);
        return {rw, md, bs, ps, mw, fs, mb, ma, cs};
    endfunction

    function automatic logic [29:0] dut_word();
        return {RW, MD, BS, PS, MW, FS, MB, MA, CS, DA, AA, BA};
    endfunction

    task automatic check_word(input logic [29:0] exp, input string name);
        n_checks++;
        if (dut_word() !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, dut_word(), exp);
        end
    endtask

    // Drive one instruction at the falling edge, push its expected output,
    // then pop and compare just after the next rising edge.
    task automatic step(input logic [31:0] ir, input logic rst,
                        input logic [29:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        IR    = ir;
        reset = rst;
        e.word = exp;
        e.name = name;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check_word(e.word, e.name);
        end
    endtask

    localparam logic [31:0] IR_ADD = 32'h04518800;
    localparam logic [31:0] IR_OR  = 32'h14518800;

    logic [29:0] exp_add, exp_or;
    logic [31:0] ir_v;

    initial begin
        vecs[0]  = '{7'b0000000, c(0,2'b00,2'b00,0,0,5'b00000,0,0,0), "NOP"};
        vecs[1]  = '{7'b1000000, c(1,2'b00,2'b00,0,0,5'b00000,0,0,0), "MOV"};
        vecs[2]  = '{7'b0000010, c(1,2'b00,2'b00,0,0,5'b00010,0,0,0), "ADD"};
        vecs[3]  = '{7'b0000101, c(1,2'b00,2'b00,0,0,5'b00101,0,0,0), "SUB"};
        vecs[4]  = '{7'b0001000, c(1,2'b00,2'b00,0,0,5'b01000,0,0,0), "AND"};
        vecs[5]  = '{7'b0001010, c(1,2'b00,2'b00,0,0,5'b01010,0,0,0), "OR"};
        vecs[6]  = '{7'b0001100, c(1,2'b00,2'b00,0,0,5'b01100,0,0,0), "XOR"};
        vecs[7]  = '{7'b0101110, c(1,2'b00,2'b00,0,0,5'b01110,0,0,0), "NOT"};
        vecs[8]  = '{7'b1100101, c(1,2'b10,2'b00,0,0,5'b00101,0,0,0), "SLT"};
        vecs[9]  = '{7'b0100010, c(1,2'b00,2'b00,0,0,5'b00010,1,0,1), "ADI"};
        vecs[10] = '{7'b0100101, c(1,2'b00,2'b00,0,0,5'b00101,1,0,1), "SBI"};
        vecs[11] = '{7'b1100010, c(1,2'b00,2'b00,0,0,5'b00010,1,0,0), "AIU"};
        vecs[12] = '{7'b1000101, c(1,2'b00,2'b00,0,0,5'b00101,1,0,0), "SIU"};
        vecs[13] = '{7'b0101000, c(1,2'b00,2'b00,0,0,5'b01000,1,0,0), "ANI"};
        vecs[14] = '{7'b0101010, c(1,2'b00,2'b00,0,0,5'b01010,1,0,0), "ORI"};
        vecs[15] = '{7'b0101100, c(1,2'b00,2'b00,0,0,5'b01100,1,0,0), "XRI"};
        vecs[16] = '{7'b0110010, c(1,2'b00,2'b00,0,0,5'b10100,1,0,0), "LSL"};
        vecs[17] = '{7'b0110001, c(1,2'b00,2'b00,0,0,5'b11000,1,0,0), "LSR"};
        vecs[18] = '{7'b0100001, c(1,2'b01,2'b00,0,0,5'b00000,0,0,0), "LD"};
        vecs[19] = '{7'b0000001, c(0,2'b00,2'b00,0,1,5'b00000,0,0,0), "ST"};
        vecs[20] = '{7'b0100000, c(0,2'b00,2'b01,0,0,5'b00000,1,0,1), "BZ"};
        vecs[21] = '{7'b1100000, c(0,2'b00,2'b01,1,0,5'b00000,1,0,1), "BNZ"};
        vecs[22] = '{7'b1100001, c(0,2'b00,2'b10,0,0,5'b00000,0,0,0), "JMR"};
        vecs[23] = '{7'b1000100, c(0,2'b00,2'b11,0,0,5'b00000,1,0,1), "JMP"};
        vecs[24] = '{7'b0000111, c(1,2'b00,2'b11,0,0,5'b00000,1,1,1), "JML"};
        vecs[25] = '{7'b1111111, c(0,2'b00,2'b00,0,0,5'b00000,0,0,0), "UNDEF"};

        exp_add = {c(1,2'b00,2'b00,0,0,5'b00010,0,0,0), 5'd5, 5'd3, 5'd2};
        exp_or  = {c(1,2'b00,2'b00,0,0,5'b01010,0,0,0), 5'd5, 5'd3, 5'd2};

        IR    = IR_ADD;
        reset = 1'b1;

        // Reset held two cycles with an ADD present: outputs stay zero.
        step(IR_ADD, 1'b1, 30'd0, "reset_cycle1");
        step(IR_ADD, 1'b1, 30'd0, "reset_cycle2");
        step(IR_ADD, 1'b0, exp_add, "first_after_reset_add");

        step(32'h0000_0000, 1'b0, 30'd0, "nop_zero");

        // Back-to-back ADD/OR: each decode visible for exactly one cycle.
        step(IR_ADD, 1'b0, exp_add, "b2b_add0");
        step(IR_OR,  1'b0, exp_or,  "b2b_or0");
        step(IR_ADD, 1'b0, exp_add, "b2b_add1");
        step(IR_OR,  1'b0, exp_or,  "b2b_or1");

        // IR changing mid-cycle must not disturb the registered outputs.
        IR = IR_ADD;
        #3;
        check_word(exp_or, "hold_between_edges");

        // Full opcode sweep, DR=7 SA=9 SB=4, noise in the low immediate bits.
        for (int i = 0; i < 26; i++) begin
            ir_v = {vecs[i].op, 5'd7, 5'd9, 5'd4, 10'h2A5};
            step(ir_v, 1'b0, {vecs[i].ctrl, 5'd7, 5'd9, 5'd4},
                 $sformatf("sweep_%s", vecs[i].name));
        end

        // Reset arriving mid-stream while an LD is present.
        ir_v = {7'b0100001, 5'd12, 5'd17, 5'd30, 10'h0};
        step(ir_v, 1'b0, {c(1,2'b01,2'b00,0,0,5'b00000,0,0,0), 5'd12, 5'd17, 5'd30},
             "ld_before_reset");
        step(ir_v, 1'b1, 30'd0, "reset_during_ld");
        step(ir_v, 1'b0, {c(1,2'b01,2'b00,0,0,5'b00000,0,0,0), 5'd12, 5'd17, 5'd30},
             "ld_after_reset");

        // Address fields follow IR even for an undefined opcode.
        ir_v = {7'b1111111, 5'd31, 5'd0, 5'd21, 10'h3FF};
        step(ir_v, 1'b0, {15'd0, 5'd31, 5'd0, 5'd21}, "undef_fields");

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
